alu_reservation_station: RTL and testbench
==========================================

ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter size, default 8: number of RS entries, and number of result slots.
REQ-002 Parameter rob_size, default 8: ROB depth; width of the broadcast-bus array.
REQ-003 Parameter width, default 32: data width.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port load, input, 1: allocate one entry this cycle.
REQ-007 Port pci, input, pci_t: decoded instruction (opcode, funct3, funct7, pc, i_imm, u_imm).
REQ-008 Port rd_tag, input, 4: ROB tag assigned to the incoming instruction.
REQ-009 Port rs1_i, input, sal_t: operand 1; rdy=1 means data is valid; rdy=0 means tag names the pending producer.
REQ-010 Port rs2_i, input, sal_t: operand 2, same encoding as rs1_i.
REQ-011 Port rob_broadcast_bus, input, sal_t [rob_size]: completed results, indexed by ROB tag.
REQ-012 Port alu_rs_o, output, sal_t [size]: per-entry result slot (tag, rdy, data).
REQ-013 Port stall, output, 1: all entries busy; combinational from registered state.

Function
REQ-014 The block shall hold per entry: busy, opcode, funct3, funct7, pc, imm, tag, and for each operand j/k a value, a ready flag and a source tag.
REQ-015 On load=1 with stall=0, the block shall allocate the lowest-index entry that was not busy before the edge, and set busy=1 and tag=rd_tag.
REQ-016 On load=1 with stall=1, the block shall ignore the request and leave state unchanged.
REQ-017 An entry freed on an edge shall not be reallocated on that same edge.
REQ-018 Operand k source shall be: rs2_i for op_reg; pci.i_imm (ready) for op_imm; pci.u_imm (ready) for op_auipc, with operand j forced to pci.pc (ready).
REQ-019 At allocation, a non-ready operand whose source tag satisfies rob_broadcast_bus[tag].rdy=1 shall be captured as ready in the same edge.
REQ-020 Every cycle, each busy entry shall snoop every non-ready operand; if rob_broadcast_bus[src_tag].rdy=1, it shall latch that data and set ready.
REQ-021 An entry becomes eligible in the cycle it is busy with both operands ready.
REQ-022 On the next edge, an eligible entry i shall write alu_rs_o[i] = {tag, rdy=1, result} and clear busy. Latency is one cycle from eligibility to result.
REQ-023 alu_rs_o[i].rdy shall be high for exactly one cycle per result and return to 0 the following cycle; tag and data are don't-care while rdy=0 but shall be driven to 0.
REQ-024 All eligible entries shall complete in parallel, with no arbitration.
REQ-025 The ALU op shall be selected by funct3: add/sub (sub only when op_reg and funct7[5]=1), sll, slt, sltu, xor, srl/sra (funct7[5]), or, and.
REQ-026 op_auipc shall always add.
REQ-027 Arithmetic shall wrap modulo 2^32; shift amount is operand k [4:0]; slt/sltu shall yield 32'h0 or 32'h1.
REQ-028 stall shall be 1 when all size entries are busy, and shall deassert in the cycle after any entry completes.
REQ-029 Load and snoop on the same edge shall both take effect.
REQ-030 An operand with source tag equal to its own entry's tag shall never occur; no handling is required.

Reset
REQ-031 With rst=1 at an edge, the block shall clear every entry's busy and ready flags and set all alu_rs_o entries to 0, so stall=0.
REQ-032 Reset mid-operation shall discard pending entries with no result emitted.
REQ-033 Reset shall take priority over load and over completion in the same cycle.

Structure
REQ-034 The types sal_t, pci_t, the opcode enum, an alu_ops enum and an rs_entry_t struct shall reside in package rv32i_types.
REQ-035 The arithmetic shall be implemented in one combinational sub-module, alu, which takes op, a and b and returns f, and is instantiated once per entry.

Verification
REQ-036 Reset, then load op_imm ADDI (i_imm=5), rs1_i ready data 10, tag 3 -> one cycle later alu_rs_o[0] = {3,1,15}, then rdy=0 on the next cycle.
REQ-037 Load op_reg SUB with rs1 ready 7 and rs2 pending tag 2; 3 cycles later drive bus[2] = {2,1,9} -> the next edge latches the operand, and the edge after that gives result 32'hFFFFFFFE, tag preserved.
REQ-038 Load 8 instructions each with a pending operand -> stall=1 and a 9th load is ignored; broadcast one tag -> that entry completes and stall=0 on the following cycle.
REQ-039 Load with rs1 pending tag 4 while bus[4].rdy=1 with data 20 in the same cycle, SLLI by 2 -> result 80 one cycle after allocation.
REQ-040 op_auipc with pc=32'h60 and u_imm=32'h1000 -> result 32'h1060.
REQ-041 Assert rst while 3 entries are busy -> no rdy pulses afterwards, stall=0, and the next load uses entry 0.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station slice.
//   sal_t        : tag/ready/data triple used for operands, broadcasts and results
//   pci_t        : decoded instruction fields handed to the station
//   rs_entry_t   : one reservation-station slot
//   rv32i_opcode : major opcodes; alu_ops : ALU functions
//   decode_op    : maps opcode/funct3/funct7[5] onto an ALU function
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [3:0] {
        alu_add, alu_sub, alu_sll, alu_slt, alu_sltu,
        alu_xor, alu_srl, alu_sra, alu_or, alu_and
    } alu_ops;

    typedef struct packed {
        logic [3:0]  tag;
        logic        rdy;
        logic [31:0] data;
    } sal_t;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] pc;
        logic [31:0] i_imm;
        logic [31:0] u_imm;
    } pci_t;

    typedef struct packed {
        logic        busy;
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  tag;
        logic [31:0] vj;
        logic        rj;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic        rk;
        logic [3:0]  qk;
    } rs_entry_t;

    // alt is funct7[5]: selects sub (register form only) and sra.
    function automatic alu_ops decode_op(input rv32i_opcode opcode,
                                         input logic [2:0] funct3,
                                         input logic alt);
        alu_ops op;
        case (funct3)
            3'b000:  op = (opcode == op_reg && alt) ? alu_sub : alu_add;
            3'b001:  op = alu_sll;
            3'b010:  op = alu_slt;
            3'b011:  op = alu_sltu;
            3'b100:  op = alu_xor;
            3'b101:  op = alt ? alu_sra : alu_srl;
            3'b110:  op = alu_or;
            default: op = alu_and;
        endcase
        if (opcode == op_auipc) op = alu_add;
        return op;
    endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch/broadcast/result bundle of the ALU reservation station.
//   load, pci, rd_tag, rs1_i, rs2_i : instruction being dispatched
//   rob_broadcast_bus               : completed results indexed by ROB tag
//   alu_rs_o                        : per-entry result slots
//   stall                           : every entry busy
// master = dispatcher side, slave = reservation station.
interface alu_reservation_station_if #(
    parameter int unsigned size     = 8,
    parameter int unsigned rob_size = 8
) ();
    import rv32i_types::*;

    logic       load;
    pci_t       pci;
    logic [3:0] rd_tag;
    sal_t       rs1_i;
    sal_t       rs2_i;
    sal_t       rob_broadcast_bus [rob_size];
    sal_t       alu_rs_o [size];
    logic       stall;

    modport master (
        output load, pci, rd_tag, rs1_i, rs2_i, rob_broadcast_bus,
        input  alu_rs_o, stall
    );

    modport slave (
        input  load, pci, rd_tag, rs1_i, rs2_i, rob_broadcast_bus,
        output alu_rs_o, stall
    );
endinterface

// File: rtl/alu_reservation_station_alu.sv
// Combinational RV32I integer ALU.
//   op : function select
//   a  : operand j
//   b  : operand k (shift amount is b[4:0])
//   f  : result, wraps modulo 2^width
module alu
    import rv32i_types::*;
#(
    parameter int unsigned width = 32
) (
    input  alu_ops             op,
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    output logic [width-1:0]   f
);
    always_comb begin
        f = '0;
        case (op)
            alu_add:  f = a + b;
            alu_sub:  f = a - b;
            alu_sll:  f = a << b[4:0];
            alu_slt:  f = {{(width-1){1'b0}}, $signed(a) < $signed(b)};
            alu_sltu: f = {{(width-1){1'b0}}, a < b};
            alu_xor:  f = a ^ b;
            alu_srl:  f = a >> b[4:0];
            alu_sra:  f = $signed(a) >>> b[4:0];
            alu_or:   f = a | b;
            alu_and:  f = a & b;
            default:  f = '0;
        endcase
    end
endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched instructions until both operands
// are ready (snooping the ROB broadcast bus), then produces the result one
// cycle later in the entry's own result slot. No issue arbitration.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   rs  : dispatch / broadcast / result bundle (slave side)
module alu_reservation_station #(
    parameter int unsigned size     = 8,
    parameter int unsigned rob_size = 8,
    parameter int unsigned width    = 32
) (
    input logic                      clk,
    input logic                      rst,
    alu_reservation_station_if.slave rs
);
    import rv32i_types::*;

    localparam int unsigned tag_bits = $clog2(rob_size);

    rs_entry_t        entries [size];
    rs_entry_t        incoming;
    sal_t             bus [rob_size];
    sal_t             results [size];
    logic [width-1:0] alu_f [size];
    logic [size-1:0]  busy;
    logic [size-1:0]  eligible;
    logic [size-1:0]  alloc_sel;
    logic             taken;
    logic             full;
    logic             unused_bits;

    always_comb begin
        for (int unsigned r = 0; r < rob_size; r++) bus[r] = rs.rob_broadcast_bus[r];
    end

    // Entry image for the instruction being dispatched, including operands
    // that are being broadcast on this very edge.
    always_comb begin
        incoming        = '0;
        incoming.busy   = 1'b1;
        incoming.opcode = rs.pci.opcode;
        incoming.funct3 = rs.pci.funct3;
        incoming.funct7 = rs.pci.funct7;
        incoming.pc     = rs.pci.pc;
        incoming.imm    = rs.pci.i_imm;
        incoming.tag    = rs.rd_tag;
        incoming.vj     = rs.rs1_i.data;
        incoming.rj     = rs.rs1_i.rdy;
        incoming.qj     = rs.rs1_i.tag;
        incoming.vk     = rs.rs2_i.data;
        incoming.rk     = rs.rs2_i.rdy;
        incoming.qk     = rs.rs2_i.tag;
        case (rs.pci.opcode)
            op_reg: ;
            op_auipc: begin
                incoming.vj  = rs.pci.pc;
                incoming.rj  = 1'b1;
                incoming.qj  = '0;
                incoming.vk  = rs.pci.u_imm;
                incoming.rk  = 1'b1;
                incoming.qk  = '0;
                incoming.imm = rs.pci.u_imm;
            end
            default: begin
                incoming.vk = rs.pci.i_imm;
                incoming.rk = 1'b1;
                incoming.qk = '0;
            end
        endcase
        if (!incoming.rj && bus[incoming.qj[tag_bits-1:0]].rdy) begin
            incoming.vj = bus[incoming.qj[tag_bits-1:0]].data;
            incoming.rj = 1'b1;
        end
        if (!incoming.rk && bus[incoming.qk[tag_bits-1:0]].rdy) begin
            incoming.vk = bus[incoming.qk[tag_bits-1:0]].data;
            incoming.rk = 1'b1;
        end
    end

    // alloc_sel is one-hot on the lowest entry free before the edge.
    always_comb begin
        taken = 1'b0;
        for (int unsigned i = 0; i < size; i++) begin
            busy[i]      = entries[i].busy;
            eligible[i]  = entries[i].busy && entries[i].rj && entries[i].rk;
            alloc_sel[i] = !entries[i].busy && !taken;
            taken        = taken | !entries[i].busy;
        end
    end

    assign full     = &busy;
    assign rs.stall = full;

    // Stored fields kept for visibility but not needed after dispatch.
    always_comb begin
        unused_bits = 1'b0;
        for (int unsigned i = 0; i < size; i++)
            unused_bits = unused_bits ^ (^{entries[i].pc, entries[i].imm,
                                           entries[i].funct7[6], entries[i].funct7[4:0]});
        for (int unsigned r = 0; r < rob_size; r++)
            unused_bits = unused_bits ^ (^bus[r].tag);
    end

    for (genvar g = 0; g < size; g++) begin : g_entry
        alu #(.width(width)) u_alu (
            .op (decode_op(entries[g].opcode, entries[g].funct3, entries[g].funct7[5])),
            .a  (entries[g].vj),
            .b  (entries[g].vk),
            .f  (alu_f[g])
        );
        assign rs.alu_rs_o[g] = results[g];
    end

    // Completion, snoop and allocation are exclusive per entry: an entry that
    // completes is not reusable until the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < size; i++) begin
                entries[i].busy <= 1'b0;
                entries[i].rj   <= 1'b0;
                entries[i].rk   <= 1'b0;
                results[i]      <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < size; i++) begin
                results[i] <= '0;
                if (eligible[i]) begin
                    results[i]      <= '{tag: entries[i].tag, rdy: 1'b1, data: alu_f[i]};
                    entries[i].busy <= 1'b0;
                end else if (entries[i].busy) begin
                    if (!entries[i].rj && bus[entries[i].qj[tag_bits-1:0]].rdy) begin
                        entries[i].vj <= bus[entries[i].qj[tag_bits-1:0]].data;
                        entries[i].rj <= 1'b1;
                    end
                    if (!entries[i].rk && bus[entries[i].qk[tag_bits-1:0]].rdy) begin
                        entries[i].vk <= bus[entries[i].qk[tag_bits-1:0]].data;
                        entries[i].rk <= 1'b1;
                    end
                end else if (rs.load && !full && alloc_sel[i]) begin
                    entries[i] <= incoming;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios plus randomized
// traffic, every cycle compared against a per-slot behavioural model.
module tb_alu_reservation_station;
    import rv32i_types::*;

    localparam int unsigned n_ent = 8;
    localparam int unsigned n_rob = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_reservation_station_if #(.size(n_ent), .rob_size(n_rob)) rs_if ();

    alu_reservation_station #(.size(n_ent), .rob_size(n_rob), .width(32)) dut (
        .clk (clk),
        .rst (rst),
        .rs  (rs_if)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference model: one record per slot.
    bit          m_busy [n_ent];
    logic [3:0]  m_tag  [n_ent];
    logic [31:0] m_a    [n_ent];
    logic [31:0] m_b    [n_ent];
    bit          m_ra   [n_ent];
    bit          m_rb   [n_ent];
    logic [3:0]  m_sa   [n_ent];
    logic [3:0]  m_sb   [n_ent];
    logic [2:0]  m_f3   [n_ent];
    bit          m_alt  [n_ent];
    logic [36:0] m_out  [n_ent];
    bit          m_stall;

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh = b[4:0];
        logic [31:0] fill;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return 32'($signed(a) < $signed(b));
            3'd3: return 32'(a < b);
            3'd4: return a ^ b;
            3'd5: begin
                fill = (alt && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
                return (a >> sh) | fill;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic sal_t mk(input logic [3:0] t, input logic r, input logic [31:0] d);
        sal_t s;
        s.tag = t; s.rdy = r; s.data = d;
        return s;
    endfunction

    task automatic model_step();
        bit pre_busy [n_ent];
        bit all_busy = 1'b1;
        bit placed = 1'b0;
        sal_t bw;
        if (rst) begin
            for (int i = 0; i < n_ent; i++) begin
                m_busy[i] = 0; m_ra[i] = 0; m_rb[i] = 0; m_out[i] = '0;
            end
            m_stall = 0;
            return;
        end
        for (int i = 0; i < n_ent; i++) begin
            pre_busy[i] = m_busy[i];
            all_busy &= m_busy[i];
        end
        for (int i = 0; i < n_ent; i++) begin
            m_out[i] = '0;
            if (m_busy[i] && m_ra[i] && m_rb[i]) begin
                m_out[i]  = {m_tag[i], 1'b1, ref_alu(m_f3[i], m_alt[i], m_a[i], m_b[i])};
                m_busy[i] = 0;
            end else if (m_busy[i]) begin
                bw = rs_if.rob_broadcast_bus[m_sa[i][2:0]];
                if (!m_ra[i] && bw.rdy) begin m_a[i] = bw.data; m_ra[i] = 1; end
                bw = rs_if.rob_broadcast_bus[m_sb[i][2:0]];
                if (!m_rb[i] && bw.rdy) begin m_b[i] = bw.data; m_rb[i] = 1; end
            end
        end
        if (rs_if.load && !all_busy) begin
            for (int i = 0; i < n_ent; i++) begin
                if (!pre_busy[i] && !placed) begin
                    placed    = 1;
                    m_busy[i] = 1;
                    m_tag[i]  = rs_if.rd_tag;
                    m_a[i] = rs_if.rs1_i.data; m_ra[i] = rs_if.rs1_i.rdy; m_sa[i] = rs_if.rs1_i.tag;
                    m_b[i] = rs_if.rs2_i.data; m_rb[i] = rs_if.rs2_i.rdy; m_sb[i] = rs_if.rs2_i.tag;
                    m_f3[i]  = rs_if.pci.funct3;
                    m_alt[i] = rs_if.pci.funct7[5] &&
                               ((rs_if.pci.funct3 == 3'd5) ||
                                (rs_if.pci.funct3 == 3'd0 && rs_if.pci.opcode == op_reg));
                    if (rs_if.pci.opcode == op_auipc) begin
                        m_a[i] = rs_if.pci.pc;    m_ra[i] = 1;
                        m_b[i] = rs_if.pci.u_imm; m_rb[i] = 1;
                        m_f3[i] = 3'd0; m_alt[i] = 0;
                    end else if (rs_if.pci.opcode == op_imm) begin
                        m_b[i] = rs_if.pci.i_imm; m_rb[i] = 1;
                    end
                    bw = rs_if.rob_broadcast_bus[m_sa[i][2:0]];
                    if (!m_ra[i] && bw.rdy) begin m_a[i] = bw.data; m_ra[i] = 1; end
                    bw = rs_if.rob_broadcast_bus[m_sb[i][2:0]];
                    if (!m_rb[i] && bw.rdy) begin m_b[i] = bw.data; m_rb[i] = 1; end
                end
            end
        end
        m_stall = 1;
        for (int i = 0; i < n_ent; i++) m_stall &= m_busy[i];
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < n_ent; i++)
            check_eq($sformatf("slot%0d", i), 64'(rs_if.alu_rs_o[i]), 64'(m_out[i]));
        check_eq("stall", 64'(rs_if.stall), 64'(m_stall));
    endtask

    task automatic idle();
        rs_if.load = 1'b0;
        for (int t = 0; t < n_rob; t++) rs_if.rob_broadcast_bus[t] = mk(4'(t), 1'b0, 32'h0);
    endtask

    task automatic set_bus(input int t, input logic [31:0] d);
        rs_if.rob_broadcast_bus[t] = mk(4'(t), 1'b1, d);
    endtask

    task automatic load_instr(input rv32i_opcode opc, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] pc, input logic [31:0] iimm, input logic [31:0] uimm,
                              input logic [3:0] tag, input sal_t r1, input sal_t r2);
        rs_if.load       = 1'b1;
        rs_if.pci.opcode = opc;
        rs_if.pci.funct3 = f3;
        rs_if.pci.funct7 = f7;
        rs_if.pci.pc     = pc;
        rs_if.pci.i_imm  = iimm;
        rs_if.pci.u_imm  = uimm;
        rs_if.rd_tag     = tag;
        rs_if.rs1_i      = r1;
        rs_if.rs2_i      = r2;
    endtask

    task automatic random_cycle();
        rst = ($urandom_range(0, 99) == 0);
        case ($urandom_range(0, 2))
            0: rs_if.pci.opcode = op_reg;
            1: rs_if.pci.opcode = op_imm;
            default: rs_if.pci.opcode = op_auipc;
        endcase
        rs_if.load       = 1'($urandom_range(0, 1));
        rs_if.pci.funct3 = 3'($urandom);
        rs_if.pci.funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        rs_if.pci.pc     = $urandom;
        rs_if.pci.i_imm  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
        rs_if.pci.u_imm  = $urandom;
        rs_if.rd_tag     = 4'($urandom);
        rs_if.rs1_i      = mk(4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
        rs_if.rs2_i      = mk(4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
        for (int t = 0; t < n_rob; t++)
            rs_if.rob_broadcast_bus[t] = mk(4'(t), 1'($urandom_range(0, 3) == 0), $urandom);
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        load_instr(op_imm, 3'd0, 7'd0, 32'h0, 32'h0, 32'h0, 4'd0, mk(0, 1, 0), mk(0, 1, 0));
        rs_if.load = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_eq("reset_stall", 64'(rs_if.stall), 64'd0);
        check_eq("reset_slot0", 64'(rs_if.alu_rs_o[0]), 64'd0);

        // ADDI 10 + 5, tag 3
        load_instr(op_imm, 3'd0, 7'd0, 32'h0, 32'd5, 32'h0, 4'd3, mk(0, 1, 10), mk(0, 1, 0));
        step(); idle(); step();
        check_eq("addi_result", 64'(rs_if.alu_rs_o[0]), {27'd0, 4'd3, 1'b1, 32'd15});
        step();
        check_eq("addi_pulse_end", 64'(rs_if.alu_rs_o[0].rdy), 64'd0);

        // SUB 7 - 9 with rs2 pending on tag 2
        load_instr(op_reg, 3'd0, 7'h20, 32'h0, 32'h0, 32'h0, 4'd5, mk(0, 1, 7), mk(2, 0, 0));
        step(); idle(); step(); step();
        set_bus(2, 32'd9);
        step(); idle(); step();
        check_eq("sub_result", 64'(rs_if.alu_rs_o[0]), {27'd0, 4'd5, 1'b1, 32'hFFFF_FFFE});

        // Fill all entries, each waiting on tag i
        for (int i = 0; i < n_ent; i++) begin
            load_instr(op_reg, 3'd0, 7'd0, 32'h0, 32'h0, 32'h0, 4'(i), mk(0, 1, 32'(i)), mk(4'(i), 0, 0));
            step();
        end
        check_eq("full_stall", 64'(rs_if.stall), 64'd1);
        load_instr(op_imm, 3'd0, 7'd0, 32'h0, 32'd1, 32'h0, 4'd15, mk(0, 1, 1), mk(0, 1, 0));
        step(); idle();
        check_eq("ignored_load_stall", 64'(rs_if.stall), 64'd1);
        set_bus(3, 32'd100);
        step(); idle(); step();
        check_eq("slot3_result", 64'(rs_if.alu_rs_o[3]), {27'd0, 4'd3, 1'b1, 32'd103});
        check_eq("stall_release", 64'(rs_if.stall), 64'd0);
        for (int t = 0; t < n_rob; t++) set_bus(t, 32'(t * 3));
        step(); idle(); step(); step();

        // SLLI with operand captured on the allocation edge
        set_bus(4, 32'd20);
        load_instr(op_imm, 3'd1, 7'd0, 32'h0, 32'd2, 32'h0, 4'd6, mk(4, 0, 0), mk(0, 1, 0));
        step(); idle(); step();
        check_eq("slli_capture", 64'(rs_if.alu_rs_o[0]), {27'd0, 4'd6, 1'b1, 32'd80});

        // AUIPC ignores funct3/funct7 and the rs operands
        load_instr(op_auipc, 3'd5, 7'h20, 32'h60, 32'h0, 32'h1000, 4'd7, mk(5, 0, 0), mk(6, 0, 0));
        step(); idle(); step();
        check_eq("auipc_result", 64'(rs_if.alu_rs_o[0]), {27'd0, 4'd7, 1'b1, 32'h1060});

        // Reset with three pending entries and one eligible entry
        for (int i = 0; i < 3; i++) begin
            load_instr(op_reg, 3'd0, 7'd0, 32'h0, 32'h0, 32'h0, 4'(10 + i), mk(0, 1, 1), mk(4'(i + 1), 0, 0));
            step();
        end
        load_instr(op_imm, 3'd0, 7'd0, 32'h0, 32'd1, 32'h0, 4'd13, mk(0, 1, 1), mk(0, 1, 0));
        step();
        rst = 1'b1;
        set_bus(1, 32'd5);
        step();
        rst = 1'b0;
        idle();
        check_eq("rst_blocks_completion", 64'(rs_if.alu_rs_o[3]), 64'd0);
        check_eq("rst_stall", 64'(rs_if.stall), 64'd0);
        for (int t = 1; t < 4; t++) set_bus(t, 32'd1);
        repeat (4) step();
        idle();
        load_instr(op_imm, 3'd0, 7'd0, 32'h0, 32'd1, 32'h0, 4'd9, mk(0, 1, 1), mk(0, 1, 0));
        step(); idle(); step();
        check_eq("post_rst_entry0", 64'(rs_if.alu_rs_o[0]), {27'd0, 4'd9, 1'b1, 32'd2});

        repeat (1500) random_cycle();
        rst = 1'b0;
        idle();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
